// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter slice.
package data_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;

    function automatic arb_state_e own_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_arb_pick2.sv
// Combinational winner selection between the CPU and I/O requesters.
module arb_pick2
    import data_mem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  arb_state_e       state,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             last_served,
    output logic             winner_valid,
    output logic             winner_id
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic owner_valid;
    logic owner_id;

    always_comb begin
        owner_valid  = (state == OWN0) || (state == OWN1);
        owner_id     = (state == OWN1);
        winner_valid = 1'b0;
        winner_id    = REQ_CPU;

        // A lock only counts for the current owner; it beats the burst limit.
        if (owner_valid && req[owner_id] && lock[owner_id]) begin
            winner_valid = 1'b1;
            winner_id    = owner_id;
        end else if (req == 2'b01) begin
            winner_valid = 1'b1;
            winner_id    = REQ_CPU;
        end else if (req == 2'b10) begin
            winner_valid = 1'b1;
            winner_id    = REQ_IO;
        end else if (req == 2'b11) begin
            winner_valid = 1'b1;
            if (owner_valid)
                winner_id = (burst_cnt < BURST_MAX) ? owner_id : ~owner_id;
            else
                winner_id = ~last_served;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data RAM.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_e       state, state_nxt;
    logic             last_served, last_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;
    logic             rd_pend0, rd_pend1;
    logic             winner_valid, winner_id;
    logic             grant_valid;

    arb_pick2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .req          ({req1, req0}),
        .lock         ({lock1, lock0}),
        .state        (state),
        .burst_cnt    (burst_cnt),
        .last_served  (last_served),
        .winner_valid (winner_valid),
        .winner_id    (winner_id)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= REQ_IO;
            burst_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            last_served <= last_nxt;
            burst_cnt   <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        last_nxt  = last_served;
        burst_nxt = '0;
        if (winner_valid) begin
            state_nxt = own_state(winner_id);
            last_nxt  = winner_id;
            if (state == state_nxt)
                burst_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
            else
                burst_nxt = CNT_W'(1);
        end
    end

    // Reset suppresses all grants so nothing reaches the RAM while it is held.
    always_comb begin
        grant_valid = winner_valid && !reset;
        gnt0        = grant_valid && (winner_id == REQ_CPU);
        gnt1        = grant_valid && (winner_id == REQ_IO);
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rd_pend0 <= gnt0 && !we0;
            rd_pend1 <= gnt1 && !we1;
        end
    end

    assign rvalid0 = rd_pend0 && !reset;
    assign rvalid1 = rd_pend1 && !reset;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed table-driven bench for data_mem_arbiter with a behavioural RAM.
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic [15:0] ram [256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r0, r1, w0, w1, l0, l1;
        logic [7:0]  a0, a1;
        logic [15:0] d0, d1;
        logic        g0, g1, rv0, rv1, mwe;
        logic [7:0]  maddr;
        logic [15:0] mwdata;
        logic [15:0] erdata;
    } vec_t;

    vec_t vecs[$];

    data_mem_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .MAX_BURST (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(
        input logic r0, r1, w0, w1, l0, l1,
        input logic [7:0] a0, a1, input logic [15:0] d0, d1,
        input logic g0, g1, rv0, rv1, mwe,
        input logic [7:0] maddr, input logic [15:0] mwdata, erdata);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.mwe = mwe;
        v.maddr = maddr; v.mwdata = mwdata; v.erdata = erdata;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r0, r1, w0, w1, l0, l1,
                         input logic [7:0] a0, a1, input logic [15:0] d0, d1);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);

        // Tie from reset, then burst limit alternation 0,0,0,0,1,1,1,1,0.
        add_vec(1,1,0,0,0,0, 8'h10,8'h20, 16'h1111,16'h2222, 1,0,0,0,0, 8'h10,16'h1111,16'h0000);
        for (int k = 0; k < 3; k++)
            add_vec(1,1,0,0,0,0, 8'h10,8'h20, 16'h1111,16'h2222, 1,0,1,0,0, 8'h10,16'h1111,16'hA010);
        add_vec(1,1,0,0,0,0, 8'h10,8'h20, 16'h1111,16'h2222, 0,1,1,0,0, 8'h20,16'h2222,16'hA010);
        for (int k = 0; k < 3; k++)
            add_vec(1,1,0,0,0,0, 8'h10,8'h20, 16'h1111,16'h2222, 0,1,0,1,0, 8'h20,16'h2222,16'hA020);
        add_vec(1,1,0,0,0,0, 8'h10,8'h20, 16'h1111,16'h2222, 1,0,0,1,0, 8'h10,16'h1111,16'hA020);
        // Owner lock holds past the burst limit for 10 cycles.
        for (int k = 0; k < 10; k++)
            add_vec(1,1,0,0,1,0, 8'h10,8'h20, 16'h1111,16'h2222, 1,0,1,0,0, 8'h10,16'h1111,16'hA010);
        add_vec(1,1,0,0,0,0, 8'h10,8'h20, 16'h1111,16'h2222, 0,1,1,0,0, 8'h20,16'h2222,16'hA010);
        // Ownership to 0, then lock1 from the non-owner is ignored.
        add_vec(1,0,0,0,0,0, 8'h10,8'h20, 16'h1111,16'h2222, 1,0,0,1,0, 8'h10,16'h1111,16'hA020);
        for (int k = 0; k < 3; k++)
            add_vec(1,1,0,0,0,1, 8'h10,8'h20, 16'h1111,16'h2222, 1,0,1,0,0, 8'h10,16'h1111,16'hA010);
        add_vec(1,1,0,0,0,1, 8'h10,8'h20, 16'h1111,16'h2222, 0,1,1,0,0, 8'h20,16'h2222,16'hA010);
        // Write from requester 1, read back by requester 0.
        add_vec(0,1,0,1,0,0, 8'h10,8'h05, 16'h1111,16'hBEEF, 0,1,0,1,1, 8'h05,16'hBEEF,16'hA020);
        add_vec(1,0,0,0,0,0, 8'h05,8'h05, 16'h1111,16'hBEEF, 1,0,0,0,0, 8'h05,16'h1111,16'h0000);
        add_vec(0,0,0,0,0,0, 8'h05,8'h05, 16'h1111,16'hBEEF, 0,0,1,0,0, 8'h00,16'h0000,16'hBEEF);
        add_vec(0,0,0,0,0,0, 8'h05,8'h05, 16'h1111,16'hBEEF, 0,0,0,0,0, 8'h00,16'h0000,16'h0000);

        reset = 1'b1;
        drive(0,0,0,0,0,0, 8'h00,8'h00, 16'h0000,16'h0000);
        repeat (2) @(posedge clock);
        #1;
        drive(1,1,1,1,0,0, 8'h33,8'h44, 16'h5555,16'h6666);
        @(negedge clock);
        check("rst gnt0", 16'(gnt0), 16'h0);
        check("rst gnt1", 16'(gnt1), 16'h0);
        check("rst mem_we", 16'(mem_we), 16'h0);
        check("rst rvalid0", 16'(rvalid0), 16'h0);
        check("rst rvalid1", 16'(rvalid1), 16'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            reset = 1'b0;
            drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].l0, vecs[i].l1,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clock);
            check($sformatf("v%0d gnt0", i), 16'(gnt0), 16'(vecs[i].g0));
            check($sformatf("v%0d gnt1", i), 16'(gnt1), 16'(vecs[i].g1));
            check($sformatf("v%0d rvalid0", i), 16'(rvalid0), 16'(vecs[i].rv0));
            check($sformatf("v%0d rvalid1", i), 16'(rvalid1), 16'(vecs[i].rv1));
            check($sformatf("v%0d mem_we", i), 16'(mem_we), 16'(vecs[i].mwe));
            check($sformatf("v%0d mem_addr", i), 16'(mem_addr), 16'(vecs[i].maddr));
            check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwdata);
            if (vecs[i].rv0 || vecs[i].rv1)
                check($sformatf("v%0d rdata", i), rdata, vecs[i].erdata);
        end

        // Reset arriving the cycle after a requester-1 read grant.
        @(posedge clock); #1;
        drive(0,1,0,0,0,0, 8'h00,8'h30, 16'h0000,16'h0000);
        @(negedge clock);
        check("mid gnt1", 16'(gnt1), 16'h1);
        check("mid mem_addr", 16'(mem_addr), 16'h0030);

        @(posedge clock); #1;
        reset = 1'b1;
        drive(0,0,0,0,0,0, 8'h00,8'h00, 16'h0000,16'h0000);
        @(negedge clock);
        check("mid rst rvalid1", 16'(rvalid1), 16'h0);
        check("mid rst rdata", rdata, 16'hA030);

        @(posedge clock); #1;
        reset = 1'b0;
        drive(1,1,0,0,0,0, 8'h40,8'h50, 16'h0000,16'h0000);
        @(negedge clock);
        check("post rst gnt0", 16'(gnt0), 16'h1);
        check("post rst gnt1", 16'(gnt1), 16'h0);
        check("post rst rvalid1", 16'(rvalid1), 16'h0);

        @(posedge clock); #1;
        drive(0,0,0,0,0,0, 8'h00,8'h00, 16'h0000,16'h0000);
        @(negedge clock);
        check("post rst rvalid0", 16'(rvalid0), 16'h1);
        check("post rst rdata", rdata, 16'hA040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
